// File: rtl/combo_pkg.sv
// combo_pkg: shared state encoding, bit levels and default timing for the combination lock interface
// Contents: combo_state_t (shared with the lock receiver), LOW/HIGH levels, DEF_* timing defaults, max4 helper.
package combo_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, CHECK, DONE} combo_state_t;
  localparam logic LOW = 1'b0;
  localparam logic HIGH = 1'b1;
  localparam int DEF_CODE_LEN = 5;
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_HIGH_CYC = 2;
  localparam int DEF_GAP_CYC = 2;
  localparam int DEF_UNLOCK_WAIT = 4;
  localparam int DEF_MAX_RETRY = 3;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction
endpackage

// File: rtl/combo_phase_timer.sv
// combo_phase_timer: loadable down-counter whose last flag marks the final cycle of a phase
// Ports: clk, reset (sync active-low), load/val reload the count, last is high while the count equals 1.
module combo_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         last
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign last = (cnt == W'(1));
endmodule

// File: rtl/combination_sender.sv
// combination_sender: serialize a latched code onto key/update and report the lock's unlock result
// Ports: clk, reset (sync active-low); start/code request an attempt, unlock comes from the receiver;
//        key/update carry the bit stream, busy/done/pass form the host handshake. All outputs registered.
// Optional: define COMBO_SEND_RETRY_EN to retry a failed attempt up to MAX_RETRY times before done.
module combination_sender
  import combo_pkg::*;
#(
  parameter int CODE_LEN    = DEF_CODE_LEN,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int HIGH_CYC    = DEF_HIGH_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int UNLOCK_WAIT = DEF_UNLOCK_WAIT,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code,
  input  logic                unlock,
  output logic                key,
  output logic                update,
  output logic                busy,
  output logic                done,
  output logic                pass
);
  localparam int CW = $clog2(max4(SETUP_CYC, HIGH_CYC, GAP_CYC, UNLOCK_WAIT) + 1);
  localparam int IW = $clog2(CODE_LEN + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(CODE_LEN - 1);
  if (CODE_LEN < 1 || SETUP_CYC < 1 || HIGH_CYC < 1 || GAP_CYC < 1 || UNLOCK_WAIT < 1 || MAX_RETRY < 0) begin : g_bad_param
    $error("combination_sender: illegal parameter value");
  end
  combo_state_t state, nxt;
  logic [CODE_LEN-1:0] sh, sh_n;
  logic [IW-1:0] idx, idx_n;
  logic key_n, update_n, busy_n, done_n, pass_n;
  logic ld, last;
  logic [CW-1:0] lv;
`ifdef COMBO_SEND_RETRY_EN
  localparam int AW = $clog2(MAX_RETRY + 2);
  logic [CODE_LEN-1:0] code_q;
  logic [AW-1:0] att, att_n;
  logic rg, rg_n;
`endif
  combo_phase_timer #(.W(CW)) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (ld),
    .val  (lv),
    .last (last)
  );
  always_comb begin
    nxt = state;
    ld = 1'b0;
    lv = '0;
    sh_n = sh;
    idx_n = idx;
    key_n = key;
    update_n = update;
    busy_n = busy;
    done_n = LOW;
    pass_n = pass;
`ifdef COMBO_SEND_RETRY_EN
    att_n = att;
    rg_n = rg;
`endif
    case (state)
      IDLE: if (start) begin
        nxt = SETUP;
        ld = 1'b1;
        lv = CW'(SETUP_CYC);
        sh_n = code;
        idx_n = '0;
        key_n = code[CODE_LEN-1];
        busy_n = HIGH;
        pass_n = LOW;
`ifdef COMBO_SEND_RETRY_EN
        att_n = AW'(1);
        rg_n = LOW;
`endif
      end
      SETUP: if (last) begin
        nxt = PULSE;
        ld = 1'b1;
        lv = CW'(HIGH_CYC);
        update_n = HIGH;
      end
      PULSE: if (last) begin
        nxt = GAP;
        ld = 1'b1;
        lv = CW'(GAP_CYC);
        update_n = LOW;
      end
      GAP: if (last) begin
        nxt = SETUP;
        ld = 1'b1;
        lv = CW'(SETUP_CYC);
`ifdef COMBO_SEND_RETRY_EN
        // a retry gap restarts the whole code from the latched copy
        if (rg) begin
          sh_n = code_q;
          idx_n = '0;
          key_n = code_q[CODE_LEN-1];
          rg_n = LOW;
        end else
`endif
        if (idx != LAST_IDX) begin
          sh_n = sh << 1;
          idx_n = idx + 1'b1;
          key_n = sh_n[CODE_LEN-1];
        end else begin
          nxt = CHECK;
          lv = CW'(UNLOCK_WAIT);
          key_n = LOW;
        end
      end
      CHECK: begin
        // pass is sticky across the sampling window
        pass_n = pass | unlock;
        if (last) begin
          nxt = DONE;
          done_n = HIGH;
          busy_n = LOW;
`ifdef COMBO_SEND_RETRY_EN
          if (!pass_n && att != AW'(MAX_RETRY + 1)) begin
            nxt = GAP;
            done_n = LOW;
            busy_n = HIGH;
            rg_n = HIGH;
            att_n = att + 1'b1;
            ld = 1'b1;
            lv = CW'(GAP_CYC);
          end
`endif
        end
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
      key <= LOW;
      update <= LOW;
      busy <= LOW;
      done <= LOW;
      pass <= LOW;
    end else begin
      state <= nxt;
      sh <= sh_n;
      idx <= idx_n;
      key <= key_n;
      update <= update_n;
      busy <= busy_n;
      done <= done_n;
      pass <= pass_n;
    end
`ifdef COMBO_SEND_RETRY_EN
  always_ff @(posedge clk)
    if (!reset) begin
      code_q <= '0;
      att <= '0;
      rg <= LOW;
    end else begin
      if (state == IDLE && start) code_q <= code;
      att <= att_n;
      rg <= rg_n;
    end
`endif
endmodule

// File: tb/tb_combination_sender.sv
// tb_combination_sender: randomized scoreboard bench for combination_sender with a behavioural lock
module tb_combination_sender;
  localparam int CL = 5, S = 2, H = 2, G = 2, U = 4, MR = 3;
  localparam logic [CL-1:0] SECRET = 5'b01011;
  localparam int T = CL * (S + H + G) + U;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [CL-1:0] code = '0;
  logic unlock, key, update, busy, done, pass;
  combination_sender #(
    .CODE_LEN(CL), .SETUP_CYC(S), .HIGH_CYC(H), .GAP_CYC(G), .UNLOCK_WAIT(U), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .code(code), .unlock(unlock),
    .key(key), .update(update), .busy(busy), .done(done), .pass(pass)
  );
  always #5 clk = ~clk;
  // lock receiver: remembers the last CL bits seen on update rising edges
  logic [CL-1:0] hist = '0;
  logic lpu = 1'b0;
  always @(posedge clk) begin
    lpu <= update;
    if (update && !lpu) hist <= {hist[CL-2:0], key};
  end
  assign unlock = (hist == SECRET);
  typedef struct {
    logic [CL-1:0] code;
    bit            pass;
    int            att;
    int            busy_cyc;
    int            done_cyc;
  } exp_t;
  exp_t q[$];
  int cyc = 0, next_drive = 0, n_chk = 0, n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic int attempts(input bit p);
`ifdef COMBO_SEND_RETRY_EN
    return p ? 1 : MR + 1;
`else
    return 1;
`endif
  endfunction
  function automatic int lat(input int a);
    return a * T + (a - 1) * G;
  endfunction
  function automatic logic [CL-1:0] rnd();
    return CL'($urandom);
  endfunction
  function automatic logic [CL-1:0] rnd_code();
    return ($urandom_range(0, 2) == 0) ? SECRET : rnd();
  endfunction
  task automatic tick(input bit st, input logic [CL-1:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    start = st;
    code = c;
    if (st && reset && cyc >= next_drive) begin
      e.code = c;
      e.pass = (c == SECRET);
      e.att = attempts(e.pass);
      e.busy_cyc = cyc + 1;
      e.done_cyc = cyc + 1 + lat(e.att);
      q.push_back(e);
      next_drive = e.done_cyc + 1;
    end
  endtask
  task automatic send(input logic [CL-1:0] c, input int hold);
    while (cyc + 1 < next_drive) tick(1'b0, rnd());
    tick(1'b1, c);
    for (int i = 1; i < hold; i++) tick(1'b1, rnd());
    tick(1'b0, rnd());
  endtask
  task automatic abort_test(input logic [CL-1:0] c);
    send(c, 1);
    repeat (14) tick(1'b0, rnd());
    chk(update == 1'b1, "third_pulse_update", int'(update), 1);
    reset = 1'b0;
    q.delete();
    tick(1'b0, rnd());
    chk(key == 1'b0, "abort_key", int'(key), 0);
    chk(update == 1'b0, "abort_update", int'(update), 0);
    chk(busy == 1'b0, "abort_busy", int'(busy), 0);
    chk(done == 1'b0, "abort_done", int'(done), 0);
    reset = 1'b1;
    next_drive = cyc;
  endtask
  bit got[$];
  int hi = 0;
  logic pu = 1'b0, pb = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (!reset) begin
      got.delete();
      hi = 0;
      pu = 1'b0;
      pb = 1'b0;
    end else begin
      if (update) begin
        if (!pu) got.push_back(key);
        hi++;
      end else if (pu) begin
        chk(hi == H, "pulse_width", hi, H);
        hi = 0;
      end
      if (busy && !pb) begin
        if (q.size() == 0) chk(1'b0, "busy_unexpected", cyc, -1);
        else chk(q[0].busy_cyc == cyc, "busy_rise_cycle", cyc, q[0].busy_cyc);
      end
      if (done) begin
        if (q.size() == 0) chk(1'b0, "spurious_done", cyc, -1);
        else begin
          int bad;
          me = q.pop_front();
          bad = -1;
          for (int j = 0; j < got.size(); j++)
            if (got[j] != me.code[CL-1-(j%CL)]) bad = j;
          chk(me.done_cyc == cyc, "done_cycle", cyc, me.done_cyc);
          chk(busy == 1'b0, "busy_at_done", int'(busy), 0);
          chk(pass == me.pass, "pass", int'(pass), int'(me.pass));
          chk(got.size() == me.att * CL, "update_edges", got.size(), me.att * CL);
          chk(bad < 0, "key_bits", bad, -1);
          got.delete();
        end
      end
      pu = update;
      pb = busy;
    end
  end
  initial begin
    repeat (3) tick(1'b0, '0);
    chk(key == 1'b0, "reset_key", int'(key), 0);
    chk(update == 1'b0, "reset_update", int'(update), 0);
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    chk(done == 1'b0, "reset_done", int'(done), 0);
    chk(pass == 1'b0, "reset_pass", int'(pass), 0);
    reset = 1'b1;
    next_drive = cyc;
    send(SECRET, 1);
    send(5'b01111, 1);
    send(rnd_code(), 50);
    abort_test(SECRET);
    send(SECRET, 1);
    repeat (25) begin
      repeat ($urandom_range(0, 3)) tick(1'b0, rnd());
      send(rnd_code(), $urandom_range(1, 3));
    end
    for (int i = 0; i < 3000 && q.size() != 0; i++) tick(1'b0, rnd());
    chk(q.size() == 0, "drain_timeout", q.size(), 0);
    repeat (3) tick(1'b0, rnd());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
